// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, taken-branch flush and dmem freeze,
// plus saturating performance counters and a sticky memory-timeout flag.
module pipe_hazard_ctrl #(
  parameter int FREEZE_TIMEOUT = 255,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             mem_branch_taken,
  input  logic             dmem_busy,
  output logic             pc_en,
  output logic             pc_sel_branch,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_bubble,
  output logic             ex_mem_en,
  output logic             ex_mem_flush,
  output logic             mem_wb_en,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic             mem_timeout_err,
  output logic [1:0]       state
);

  localparam int TO_W = $clog2(FREEZE_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FREEZE = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic [CNT_W-1:0]  r_freeze_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_timeout_err;

  logic w_hazard;
  logic w_do_freeze;
  logic w_do_flush;
  logic w_do_stall;
  logic w_to_hit;

  // A load whose destination is r0 never creates a real dependency.
  assign w_hazard    = ex_mem_read && (ex_rd != 5'd0) &&
                       ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
  assign w_do_freeze = dmem_busy;
  assign w_do_flush  = !dmem_busy && mem_branch_taken;
  assign w_do_stall  = !dmem_busy && !mem_branch_taken && (r_state != STALL) && w_hazard;
  assign w_to_hit    = dmem_busy && (r_to_cnt >= TO_W'(FREEZE_TIMEOUT - 1));

  always_comb begin
    pc_en         = 1'b1;
    pc_sel_branch = 1'b0;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_en     = 1'b1;
    ex_mem_flush  = 1'b0;
    mem_wb_en     = 1'b1;
    if (reset) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (w_do_freeze) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (w_do_flush) begin
      pc_sel_branch = 1'b1;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_flush  = 1'b1;
    end else if (w_do_stall) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_bubble = 1'b1;
    end else begin
      pc_en = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
    end else if (w_do_freeze) begin
      r_state <= FREEZE;
    end else if (w_do_stall) begin
      r_state <= STALL;
    end else begin
      r_state <= RUN;
    end
  end

  // Counters hold at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_freeze_cnt <= '0;
    end else begin
      if (w_do_stall && !(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_do_flush && !(&r_flush_cnt))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      if (w_do_freeze && !(&r_freeze_cnt))
        r_freeze_cnt <= r_freeze_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (!dmem_busy)
        r_to_cnt <= '0;
      else if (r_to_cnt != TO_W'(FREEZE_TIMEOUT))
        r_to_cnt <= r_to_cnt + TO_W'(1);
      if (w_to_hit)
        r_timeout_err <= 1'b1;
    end
  end

  assign stall_cnt       = r_stall_cnt;
  assign flush_cnt       = r_flush_cnt;
  assign freeze_cnt      = r_freeze_cnt;
  assign mem_timeout_err = r_timeout_err;
  assign state           = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a priority-rule model checked every
// negative edge, plus hand-computed literal expectations per scenario.
module tb_pipe_hazard_ctrl;

  localparam int TO   = 8;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [4:0]    id_rs, id_rt, ex_rd;
  logic          id_uses_rs, id_uses_rt, ex_mem_read, mem_branch_taken, dmem_busy;
  logic          pc_en, pc_sel_branch, if_id_en, if_id_flush, id_ex_en, id_ex_bubble;
  logic          ex_mem_en, ex_mem_flush, mem_wb_en, mem_timeout_err;
  logic [CW-1:0] stall_cnt, flush_cnt, freeze_cnt;
  logic [1:0]    state;
  logic [8:0]    ctrl_vec;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  int m_state = 0, m_stall = 0, m_flush = 0, m_freeze = 0, m_to = 0;
  bit m_err = 1'b0;

  pipe_hazard_ctrl #(.FREEZE_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .mem_branch_taken(mem_branch_taken), .dmem_busy(dmem_busy),
    .pc_en(pc_en), .pc_sel_branch(pc_sel_branch), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_bubble(id_ex_bubble), .ex_mem_en(ex_mem_en),
    .ex_mem_flush(ex_mem_flush), .mem_wb_en(mem_wb_en), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt), .mem_timeout_err(mem_timeout_err),
    .state(state)
  );

  assign ctrl_vec = {pc_en, pc_sel_branch, if_id_en, if_id_flush, id_ex_en,
                     id_ex_bubble, ex_mem_en, ex_mem_flush, mem_wb_en};

  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // Which priority rule applies this cycle: 1 reset, 2 freeze, 3 flush, 4 stall, 5 normal.
  function automatic int model_case();
    bit dep;
    dep = ex_mem_read && (ex_rd != 0) &&
          ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    if (reset) return 1;
    if (dmem_busy) return 2;
    if (mem_branch_taken) return 3;
    if (m_state != 1 && dep) return 4;
    return 5;
  endfunction

  // Control vector order: pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, bubble, ex_mem_en, ex_mem_flush, mem_wb_en.
  function automatic int model_ctrl(input int c);
    case (c)
      1:       return 9'b000101010;
      2:       return 9'b000000000;
      3:       return 9'b111111111;
      4:       return 9'b000011101;
      default: return 9'b101010101;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state <= 0; m_stall <= 0; m_flush <= 0; m_freeze <= 0; m_to <= 0; m_err <= 1'b0;
    end else begin
      m_state  <= dmem_busy ? 2 : (model_case() == 4 ? 1 : 0);
      m_stall  <= (model_case() == 4) ? sat(m_stall + 1) : m_stall;
      m_flush  <= (model_case() == 3) ? sat(m_flush + 1) : m_flush;
      m_freeze <= (model_case() == 2) ? sat(m_freeze + 1) : m_freeze;
      m_to     <= dmem_busy ? m_to + 1 : 0;
      m_err    <= m_err || (dmem_busy && (m_to + 1 >= TO));
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("ctrl", int'(ctrl_vec), model_ctrl(model_case()));
      check("state", int'(state), m_state);
      check("stall_cnt", int'(stall_cnt), m_stall);
      check("flush_cnt", int'(flush_cnt), m_flush);
      check("freeze_cnt", int'(freeze_cnt), m_freeze);
      check("timeout_err", int'(mem_timeout_err), int'(m_err));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_in();
    id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
    mem_branch_taken = 1'b0; dmem_busy = 1'b0;
  endtask

  task automatic do_reset();
    clr_in();
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
  endtask

  initial begin
    clr_in();
    chk_en = 1'b1;
    cyc(2);
    check("rst_bubble", int'(id_ex_bubble), 1);
    check("rst_state", int'(state), 0);
    reset = 1'b0;

    // Load-use stall, then the same pattern with ex_rd = 0.
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
    #1;
    check("lu_pc_en", int'(pc_en), 0);
    check("lu_if_id_en", int'(if_id_en), 0);
    check("lu_bubble", int'(id_ex_bubble), 1);
    cyc(1);
    check("lu_state1", int'(state), 1);
    check("lu_pc_en_stall", int'(pc_en), 1);
    cyc(1);
    check("lu_state0", int'(state), 0);
    check("lu_cnt", int'(stall_cnt), 1);
    ex_rd = 5'd0; id_rs = 5'd0;
    #1;
    check("lu_r0_pc_en", int'(pc_en), 1);
    cyc(2);
    check("lu_r0_cnt", int'(stall_cnt), 1);

    // Taken branch overrides a simultaneous load-use hazard.
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1; mem_branch_taken = 1'b1;
    #1;
    check("br_sel", int'(pc_sel_branch), 1);
    check("br_flushes", int'({if_id_flush, id_ex_bubble, ex_mem_flush}), 7);
    cyc(1);
    clr_in();
    check("br_flush_cnt", int'(flush_cnt), 1);
    check("br_stall_cnt", int'(stall_cnt), 0);

    // Freeze with a branch pending in MEM; flush happens on release.
    do_reset();
    dmem_busy = 1'b1; mem_branch_taken = 1'b1;
    #1;
    check("fz_enables", int'(ctrl_vec), 0);
    cyc(4);
    check("fz_cnt", int'(freeze_cnt), 4);
    check("fz_state", int'(state), 2);
    check("fz_flush_cnt0", int'(flush_cnt), 0);
    dmem_busy = 1'b0;
    #1;
    check("fz_rel_sel", int'(pc_sel_branch), 1);
    cyc(1);
    mem_branch_taken = 1'b0;
    check("fz_rel_flush_cnt", int'(flush_cnt), 1);
    check("fz_rel_state", int'(state), 0);
    cyc(1);

    // Memory timeout is sticky until reset.
    do_reset();
    dmem_busy = 1'b1;
    cyc(TO - 1);
    check("to_before", int'(mem_timeout_err), 0);
    cyc(1);
    check("to_set", int'(mem_timeout_err), 1);
    dmem_busy = 1'b0;
    cyc(3);
    check("to_sticky", int'(mem_timeout_err), 1);
    do_reset();
    check("to_cleared", int'(mem_timeout_err), 0);

    // A held hazard alternates stall/run: 40 cycles give 20 stalls, saturating at 15.
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs = 5'd3; id_uses_rs = 1'b1;
    cyc(40);
    check("sat_stall", int'(stall_cnt), CMAX);
    clr_in();
    cyc(1);

    // Misc hazard patterns through the rt path and non-matching operands.
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs = 5'd4; id_rt = 5'd9; id_uses_rt = 1'b1;
    cyc(2);
    check("rt_stall", int'(stall_cnt), 1);
    id_rt = 5'd4;
    cyc(2);
    id_rs = 5'd9; id_rt = 5'd9; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    cyc(2);
    id_uses_rs = 1'b1; id_uses_rt = 1'b1; ex_mem_read = 1'b0;
    cyc(2);
    check("misc_stall", int'(stall_cnt), 1);

    // Asynchronous reset in the middle of a freeze.
    do_reset();
    dmem_busy = 1'b1;
    cyc(3);
    check("rf_state_fz", int'(state), 2);
    #2 reset = 1'b1;
    #1;
    check("rf_state", int'(state), 0);
    check("rf_freeze_cnt", int'(freeze_cnt), 0);
    check("rf_bubble", int'(id_ex_bubble), 1);
    check("rf_pc_en", int'(pc_en), 0);
    cyc(1);
    reset = 1'b0; dmem_busy = 1'b0;
    #1;
    check("rf_run_pc_en", int'(pc_en), 1);
    cyc(1);
    check("rf_run_state", int'(state), 0);
    check("rf_run_freeze_cnt", int'(freeze_cnt), 0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
